midi_note_tx: RTL

- Serializes note-on/note-off events from the generative sequencer core into a standard MIDI byte stream: UART 8N1 at 31 250 baud on one output pin.
- Sits between the sequencer's event output and the board's MIDI OUT pin; it is the transmit end of the MIDI link.
- Emits 3-byte channel-voice messages and optionally applies running status.

---
 rtl/midi_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 65 ++++++
 rtl/midi_note_tx.sv | 124 ++++++++++++
 3 files changed

// File: rtl/midi_pkg.sv
// Shared constants and types for the MIDI note transmitter.
package midi_pkg;

    localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
    localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SEND_STATUS = 2'd1,
        SEND_D1     = 2'd2,
        SEND_D2     = 2'd3
    } msg_state_t;

    // Captured event: status byte plus the two 7-bit data fields.
    typedef struct packed {
        logic [7:0] status;
        logic [6:0] note;
        logic [6:0] velocity;
    } midi_event_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte may be started on the cycle done is high,
// which makes consecutive frames abut with no idle time.
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 384
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [3:0]       STOP_IDX  = 4'd9;

    logic             active;
    logic [3:0]       bit_cnt;
    logic [CNT_W-1:0] baud_cnt;
    logic [8:0]       shreg;
    logic             bit_end_c;
    logic             load_c;

    assign bit_end_c = active && (baud_cnt == BAUD_LAST);
    assign load_c    = start && (!active || done);

    // Frame sequencing: start bit on load, then data LSB first, then stop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active   <= 1'b0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
            shreg    <= 9'h1FF;
            tx       <= 1'b1;
            done     <= 1'b0;
        end else begin
            // done lands on the final cycle of the stop bit
            done <= active && !load_c && (bit_cnt == STOP_IDX) && (baud_cnt == BAUD_PRE);
            if (load_c) begin
                active   <= 1'b1;
                tx       <= 1'b0;
                shreg    <= {1'b1, data};
                bit_cnt  <= 4'd0;
                baud_cnt <= '0;
            end else if (active) begin
                if (bit_end_c) begin
                    baud_cnt <= '0;
                    if (bit_cnt == STOP_IDX) begin
                        active <= 1'b0;
                        tx     <= 1'b1;
                    end else begin
                        tx      <= shreg[0];
                        shreg   <= {1'b1, shreg[8:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/midi_note_tx.sv
// Note-on/off event to MIDI byte stream, with optional running status.
module midi_note_tx
    import midi_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ    = 12_000_000,
    parameter int unsigned BAUD_RATE      = 31_250,
    parameter int unsigned RUNNING_STATUS = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_note_on,
    input  logic [3:0] ev_channel,
    input  logic [6:0] ev_note,
    input  logic [6:0] ev_velocity,
    output logic       midi_tx,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

    if (CLKS_PER_BIT < 16) begin : g_rate_check
        $fatal(1, "midi_note_tx: CLKS_PER_BIT must be at least 16");
    end

    msg_state_t  state;
    msg_state_t  state_next;
    msg_state_t  tx_state_c;
    midi_event_t ev_q;
    logic [7:0]  last_status;
    logic [7:0]  in_status_c;
    logic        accept_c;
    logic        launch;
    logic        start_c;
    logic [7:0]  data_c;
    logic        status_launch_c;
    logic        byte_done;

    assign accept_c    = ev_valid && ev_ready;
    assign in_status_c = {(ev_note_on ? MIDI_NOTE_ON : MIDI_NOTE_OFF), ev_channel};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: one byte per serializer done
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    if ((RUNNING_STATUS != 0) && (in_status_c == last_status)) begin
                        state_next = SEND_D1;
                    end else begin
                        state_next = SEND_STATUS;
                    end
                end
            end
            SEND_STATUS: if (byte_done) state_next = SEND_D1;
            SEND_D1:     if (byte_done) state_next = SEND_D2;
            SEND_D2:     if (byte_done) state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    // Output logic: first byte launches the cycle after accept, later bytes on done
    always_comb begin
        start_c         = 1'b0;
        data_c          = 8'h00;
        status_launch_c = 1'b0;
        tx_state_c      = launch ? state : state_next;
        if (launch || (byte_done && (state_next != IDLE))) begin
            start_c = 1'b1;
        end
        case (tx_state_c)
            SEND_STATUS: data_c = ev_q.status;
            SEND_D1:     data_c = {1'b0, ev_q.note};
            SEND_D2:     data_c = {1'b0, ev_q.velocity};
            default:     data_c = 8'h00;
        endcase
        status_launch_c = start_c && (tx_state_c == SEND_STATUS);
    end

    // Event capture, last-status tracking and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q        <= '0;
            last_status <= 8'h00;
            launch      <= 1'b0;
            ev_ready    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            launch   <= accept_c;
            ev_ready <= (state_next == IDLE);
            busy     <= (state_next != IDLE);
            if (accept_c) begin
                ev_q.status   <= in_status_c;
                ev_q.note     <= ev_note;
                ev_q.velocity <= ev_velocity;
            end
            if (status_launch_c) begin
                last_status <= ev_q.status;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start_c),
        .data (data_c),
        .tx   (midi_tx),
        .done (byte_done)
    );

endmodule
